// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution window sequencer.
//   state_e   : sequencer FSM states
//   cnt_cmd_e : command from the FSM to the index counter
//   *_w()     : derived widths for addresses, positions and the accumulator
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    EMIT
  } state_e;

  // CMD_START and CMD_NEXT_POS both issue tap (0,0) of a fresh position in
  // the same cycle the position changes, so no cycle is lost between windows.
  typedef enum logic [1:0] {
    CMD_HOLD,
    CMD_START,
    CMD_NEXT_POS,
    CMD_TAP
  } cnt_cmd_e;

  // $clog2 collapses to 0 for a single entry; a zero-width bus is not legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int pix_addr_w(input int row_limit);
    return clog2_min1(row_limit * row_limit);
  endfunction

  function automatic int ker_addr_w(input int win);
    return clog2_min1(win * win);
  endfunction

  function automatic int pos_w(input int row_limit);
    return clog2_min1(row_limit);
  endfunction

  function automatic int tap_idx_w(input int win);
    return clog2_min1(win);
  endfunction

  // Full product width plus enough headroom for W*W terms.
  function automatic int acc_w(input int data_w, input int win);
    return 2 * data_w + $clog2(win * win);
  endfunction

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Bus between the sequencer and its environment: start/status, the shared
// pixel/kernel read port, and the valid/ready result channel.
//   master : the sequencer side
//   slave  : buffers + downstream consumer side
interface conv_window_sequencer_if
  import conv_pkg::*;
#(
  parameter int ROW_LIMIT    = 10,
  parameter int WINDOWS_SIZE = 3,
  parameter int DATA_W       = 5
);
  localparam int PIX_AW = pix_addr_w(ROW_LIMIT);
  localparam int KER_AW = ker_addr_w(WINDOWS_SIZE);
  localparam int POS_W  = pos_w(ROW_LIMIT);
  localparam int ACC_W  = acc_w(DATA_W, WINDOWS_SIZE);

  logic              start;
  logic              busy;
  logic              done;
  logic              tap_rd;
  logic [PIX_AW-1:0] pix_addr;
  logic [KER_AW-1:0] ker_addr;
  logic [DATA_W-1:0] pix_data;
  logic [DATA_W-1:0] ker_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [POS_W-1:0]  out_row;
  logic [POS_W-1:0]  out_col;

  modport master (
    input  start, pix_data, ker_data, out_ready,
    output busy, done, tap_rd, pix_addr, ker_addr,
           out_valid, out_data, out_row, out_col
  );

  modport slave (
    output start, pix_data, ker_data, out_ready,
    input  busy, done, tap_rd, pix_addr, ker_addr,
           out_valid, out_data, out_row, out_col
  );
endinterface

// File: rtl/conv_index_counter.sv
// Nested window-position (i,j) and kernel-tap (m,n) counters.
//   cmd_i       : hold / start pass / next position / next tap
//   pix_addr_o  : (i+m)*ROW_LIMIT + (j+n) of the tap being issued this cycle
//   ker_addr_o  : m*WINDOWS_SIZE + n of the tap being issued this cycle
//   row_o/col_o : current window position
//   last_tap_o  : the tap being issued is (W-1,W-1)
//   last_pos_o  : current position is the final one
module conv_index_counter
  import conv_pkg::*;
#(
  parameter int ROW_LIMIT    = 10,
  parameter int WINDOWS_SIZE = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  cnt_cmd_e                           cmd_i,
  output logic [pix_addr_w(ROW_LIMIT)-1:0]   pix_addr_o,
  output logic [ker_addr_w(WINDOWS_SIZE)-1:0] ker_addr_o,
  output logic [pos_w(ROW_LIMIT)-1:0]        row_o,
  output logic [pos_w(ROW_LIMIT)-1:0]        col_o,
  output logic                               last_tap_o,
  output logic                               last_pos_o
);
  localparam int PIX_AW = pix_addr_w(ROW_LIMIT);
  localparam int KER_AW = ker_addr_w(WINDOWS_SIZE);
  localparam int POS_W  = pos_w(ROW_LIMIT);
  localparam int IDX_W  = tap_idx_w(WINDOWS_SIZE);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(ROW_LIMIT - WINDOWS_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOWS_SIZE - 1);

  logic [POS_W-1:0] i_q, j_q, sel_i, sel_j;
  logic [IDX_W-1:0] m_q, n_q, sel_m, sel_n, m_d, n_d;
  logic [31:0]      pix_row, pix_col;

  // The tap issued this cycle: a fresh position starts at tap (0,0),
  // otherwise the stored (m,n) pointer.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_i = i_q;
    sel_j = j_q;
    sel_m = m_q;
    sel_n = n_q;
    unique case (cmd_i)
      CMD_START: begin
        sel_i = '0;
        sel_j = '0;
        sel_m = '0;
        sel_n = '0;
      end
      CMD_NEXT_POS: begin
        sel_m = '0;
        sel_n = '0;
        if (j_q == LAST_POS) begin
          sel_j = '0;
          sel_i = i_q + POS_W'(1);
        end else begin
          sel_j = j_q + POS_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Tap pointer after issuing the selected tap; wraps to (0,0) after the last.
  always_comb begin
    m_d = sel_m;
    n_d = sel_n + IDX_W'(1);
    if (sel_n == LAST_IDX) begin
      n_d = '0;
      m_d = (sel_m == LAST_IDX) ? '0 : sel_m + IDX_W'(1);
    end
  end

  always_comb begin
    pix_row    = 32'(sel_i) + 32'(sel_m);
    pix_col    = 32'(sel_j) + 32'(sel_n);
    pix_addr_o = PIX_AW'(pix_row * 32'(ROW_LIMIT) + pix_col);
    ker_addr_o = KER_AW'(32'(sel_m) * 32'(WINDOWS_SIZE) + 32'(sel_n));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      m_q <= '0;
      n_q <= '0;
    end else if (cmd_i != CMD_HOLD) begin
      i_q <= sel_i;
      j_q <= sel_j;
      m_q <= m_d;
      n_q <= n_d;
    end
  end

  assign row_o      = i_q;
  assign col_o      = j_q;
  assign last_tap_o = (sel_m == LAST_IDX) && (sel_n == LAST_IDX);
  assign last_pos_o = (i_q == LAST_POS) && (j_q == LAST_POS);

endmodule

// File: rtl/conv_window_sequencer.sv
// Convolution pass sequencer with a single shared MAC.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/busy/done, read strobe + pixel/kernel addresses,
//                returned samples, and the valid/ready result channel
// Walks every window position and kernel tap in raster order, accumulates
// pix*ker one cycle after each read, and emits one sum per position.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int ROW_LIMIT    = 10,
  parameter int WINDOWS_SIZE = 3,
  parameter int DATA_W       = 5
) (
  input logic                     clk,
  input logic                     rst_n,
  conv_window_sequencer_if.master bus
);
  localparam int PIX_AW = pix_addr_w(ROW_LIMIT);
  localparam int KER_AW = ker_addr_w(WINDOWS_SIZE);
  localparam int POS_W  = pos_w(ROW_LIMIT);
  localparam int ACC_W  = acc_w(DATA_W, WINDOWS_SIZE);
  localparam int PROD_W = 2 * DATA_W;

  state_e            state_q, state_d;
  cnt_cmd_e          cmd;
  logic              tap_rd_q, tap_rd_d;
  logic              rd_d1_q;            // read data for a tap is on the bus this cycle
  logic [PIX_AW-1:0] pix_addr_q, pix_addr_d, pix_addr_c;
  logic [KER_AW-1:0] ker_addr_q, ker_addr_d, ker_addr_c;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [PROD_W-1:0] prod;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic [POS_W-1:0]  out_row_q, out_row_d, out_col_q, out_col_d, row_c, col_c;
  logic              busy_q, busy_d, done_q, done_d;
  logic              last_tap, last_pos;

  conv_index_counter #(
    .ROW_LIMIT   (ROW_LIMIT),
    .WINDOWS_SIZE(WINDOWS_SIZE)
  ) u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_i     (cmd),
    .pix_addr_o(pix_addr_c),
    .ker_addr_o(ker_addr_c),
    .row_o     (row_c),
    .col_o     (col_c),
    .last_tap_o(last_tap),
    .last_pos_o(last_pos)
  );

  // Counter command is kept apart from the next-state logic: last_tap
  // depends on the command, and the next state depends on last_tap.
  always_comb begin
    cmd = CMD_HOLD;
    unique case (state_q)
      IDLE:    if (bus.start) cmd = CMD_START;
      ISSUE:   cmd = CMD_TAP;
      EMIT:    if (bus.out_ready && !last_pos) cmd = CMD_NEXT_POS;
      default: ;
    endcase
  end

  assign prod    = PROD_W'(bus.pix_data) * PROD_W'(bus.ker_data);
  assign acc_sum = acc_q + ACC_W'(prod);

  always_comb begin
    state_d     = state_q;
    tap_rd_d    = 1'b0;
    pix_addr_d  = pix_addr_q;
    ker_addr_d  = ker_addr_q;
    acc_d       = rd_d1_q ? acc_sum : acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d  = 1'b1;
          acc_d   = '0;
          state_d = last_tap ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (last_tap) state_d = DRAIN;
      end
      DRAIN: begin
        // Wait out the buffer read latency: leave once the final product
        // is on the bus and no read is still in flight.
        if (!tap_rd_q && rd_d1_q) begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_data_d  = acc_sum;
          out_row_d   = row_c;
          out_col_d   = col_c;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          if (last_pos) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = last_tap ? DRAIN : ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (cmd != CMD_HOLD) begin
      tap_rd_d   = 1'b1;
      pix_addr_d = pix_addr_c;
      ker_addr_d = ker_addr_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tap_rd_q    <= 1'b0;
      rd_d1_q     <= 1'b0;
      pix_addr_q  <= '0;
      ker_addr_q  <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_rd_q    <= tap_rd_d;
      rd_d1_q     <= tap_rd_q;
      pix_addr_q  <= pix_addr_d;
      ker_addr_q  <= ker_addr_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.tap_rd    = tap_rd_q;
  assign bus.pix_addr  = pix_addr_q;
  assign bus.ker_addr  = ker_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer: synchronous-read buffer
// models, a result scoreboard filled at start, and pass-level timing checks.
module tb_conv_window_sequencer;
  localparam int RL     = 10;
  localparam int WS     = 3;
  localparam int DW     = 5;
  localparam int NPOS   = RL - WS + 1;
  localparam int PER    = WS * WS + 2;
  localparam int P_EDGE = NPOS * NPOS * PER;

  typedef struct {
    int     row;
    int     col;
    longint data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_popped = 0;
  int   pix_mem [RL*RL];
  int   ker_mem [WS*WS];
  exp_t sb [$];

  always #5 clk = ~clk;

  conv_window_sequencer_if #(.ROW_LIMIT(RL), .WINDOWS_SIZE(WS), .DATA_W(DW)) bus ();

  conv_window_sequencer #(.ROW_LIMIT(RL), .WINDOWS_SIZE(WS), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Synchronous-read buffers: data appears the cycle after tap_rd.
  always @(posedge clk) begin
    if (bus.tap_rd) begin
      bus.pix_data <= DW'(pix_mem[int'(bus.pix_addr)]);
      bus.ker_data <= DW'(ker_mem[int'(bus.ker_addr)]);
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model_out(input int i, input int j);
    longint s = 0;
    for (int m = 0; m < WS; m++)
      for (int n = 0; n < WS; n++)
        s += longint'(pix_mem[(i + m) * RL + (j + n)]) * longint'(ker_mem[m * WS + n]);
    return s;
  endfunction

  task automatic push_expected();
    for (int i = 0; i < NPOS; i++)
      for (int j = 0; j < NPOS; j++)
        sb.push_back('{row: i, col: j, data: model_out(i, j)});
  endtask

  // Acceptance happens on the next rising edge; compare against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_popped++;
        check("out_data", longint'(bus.out_data), e.data);
        check("out_row", longint'(bus.out_row), longint'(e.row));
        check("out_col", longint'(bus.out_col), longint'(e.col));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tap_rd"},    longint'(bus.tap_rd), 0);
    check({tag, "_pix_addr"},  longint'(bus.pix_addr), 0);
    check({tag, "_ker_addr"},  longint'(bus.ker_addr), 0);
    check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
    check({tag, "_out_data"},  longint'(bus.out_data), 0);
    check({tag, "_out_row"},   longint'(bus.out_row), 0);
    check({tag, "_out_col"},   longint'(bus.out_col), 0);
    check({tag, "_busy"},      longint'(bus.busy), 0);
    check({tag, "_done"},      longint'(bus.done), 0);
  endtask

  // One pass. Called #1 after a rising edge. stall holds out_ready low for
  // five cycles on the first result; glitch pulses start during ISSUE;
  // abort_at > 0 asserts reset after that edge.
  task automatic run_pass(input string tag, input bit stall, input bit glitch, input int abort_at);
    int base        = n_popped;
    int first_valid = -1;
    int done_cyc    = -1;
    longint first_exp = model_out(0, 0);
    push_expected();
    bus.out_ready = !stall;
    bus.start     = 1'b1;
    @(posedge clk); #1;                       // edge 0
    bus.start = 1'b0;
    check({tag, "_tap_rd_e0"}, longint'(bus.tap_rd), 1);
    check({tag, "_busy_e0"},   longint'(bus.busy), 1);
    for (int cyc = 1; cyc < P_EDGE + 100; cyc++) begin
      @(posedge clk); #1;
      if (glitch && cyc == 3) bus.start = 1'b1;
      if (glitch && cyc == 4) bus.start = 1'b0;
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (stall && cyc >= PER - 1 && cyc < PER + 4) begin
        check({tag, "_stall_valid"}, longint'(bus.out_valid), 1);
        check({tag, "_stall_data"},  longint'(bus.out_data), first_exp);
        check({tag, "_stall_tap_rd"}, longint'(bus.tap_rd), 0);
      end
      if (stall && cyc == PER + 4) bus.out_ready = 1'b1;
      if (abort_at > 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs({tag, "_abort"});
        check({tag, "_abort_popped"}, longint'(n_popped - base), 28);
        sb.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
    end
    check({tag, "_first_valid_edge"}, longint'(first_valid), PER - 1);
    check({tag, "_done_edge"}, longint'(done_cyc), longint'(P_EDGE + (stall ? 5 : 0)));
    check({tag, "_results"}, longint'(n_popped - base), NPOS * NPOS);
    check({tag, "_sb_left"}, longint'(sb.size()), 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, longint'(bus.done), 0);
    check({tag, "_busy_end"},   longint'(bus.busy), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.pix_data  = '0;
    bus.ker_data  = '0;
    foreach (pix_mem[k]) pix_mem[k] = 0;
    foreach (ker_mem[k]) ker_mem[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All ones: every window sums to W*W.
    foreach (pix_mem[k]) pix_mem[k] = 1;
    foreach (ker_mem[k]) ker_mem[k] = 1;
    run_pass("ones", 1'b0, 1'b0, 0);

    // Row-index image with a centre-only kernel: result is i+1.
    foreach (pix_mem[k]) pix_mem[k] = k / RL;
    foreach (ker_mem[k]) ker_mem[k] = (k == (WS * WS) / 2) ? 1 : 0;
    run_pass("rowimg", 1'b0, 1'b0, 0);

    // Full-scale samples, with a stray start during ISSUE.
    foreach (pix_mem[k]) pix_mem[k] = 31;
    foreach (ker_mem[k]) ker_mem[k] = 31;
    run_pass("max_glitch", 1'b0, 1'b1, 0);

    // Random samples with backpressure on the first result.
    foreach (pix_mem[k]) pix_mem[k] = int'($urandom_range(0, 31));
    foreach (ker_mem[k]) ker_mem[k] = int'($urandom_range(0, 31));
    run_pass("stall", 1'b1, 1'b0, 0);

    // Reset mid-ISSUE of position (3,4), then a complete fresh pass.
    run_pass("abort", 1'b0, 1'b0, (3 * NPOS + 4) * PER + 4);
    run_pass("after_abort", 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Sequencer that drives one convolution pass over a square pixel matrix held in an external synchronous-read buffer. It walks every valid window position (i,j) and every kernel tap (m,n) in raster order, issuing pixel/kernel read addresses. It multiply-accumulates the returned 5-bit samples and emits one accumulated result per window position over a valid/ready output. It sits between the matrix/kernel storage and the downstream fuzzy/feature stage, and replaces the fully parallel window evaluation with a single shared MAC.

## Interface
- ROW_LIMIT, 10, matrix side length (pixels).
- WINDOWS_SIZE, 3, kernel side length; must satisfy 1 ≤ WINDOWS_SIZE ≤ ROW_LIMIT.
- DATA_W, 5, pixel and kernel sample width, unsigned.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a pass; sampled only in IDLE.
- tap_rd  out  1  read strobe for both buffers.
- pix_addr  out  $clog2(ROW_LIMIT*ROW_LIMIT)  pixel address = (i+m)*ROW_LIMIT + (j+n).
- ker_addr  out  $clog2(WINDOWS_SIZE*WINDOWS_SIZE)  kernel address = m*WINDOWS_SIZE + n.
- pix_data  in  DATA_W  pixel read data, valid one cycle after tap_rd.
- ker_data  in  DATA_W  kernel read data, valid one cycle after tap_rd.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W = 2*DATA_W + $clog2(WINDOWS_SIZE*WINDOWS_SIZE)  window sum.
- out_row, out_col  out  $clog2(ROW_LIMIT)  window position i, j.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after last result accepted.

## Operation
- States: IDLE, ISSUE, DRAIN, EMIT.
- IDLE: start=1 → ISSUE; i=j=m=n=0, accumulator cleared, busy=1. start in any other state is ignored.
- ISSUE: each cycle registers tap_rd=1 and the addresses of the current (m,n); n increments, wraps to 0 with m incrementing. After tap (W-1,W-1) is issued → DRAIN.
- Accumulator adds pix_data*ker_data one cycle after each tap_rd. Product is a full 2*DATA_W bits; the sum is unsigned, zero-extended to ACC_W, and cannot overflow.
- DRAIN: one cycle absorbing the last product; tap_rd=0 → EMIT.
- EMIT: out_valid=1, out_data/out_row/out_col held stable until out_valid&&out_ready. On acceptance: if (i,j) is the last position (ROW_LIMIT-WINDOWS_SIZE, ROW_LIMIT-WINDOWS_SIZE), go to IDLE with busy=0 and pulse done. Otherwise advance j, wrapping to 0 with i incrementing, clear the accumulator, and return to ISSUE.
- out_ready is ignored outside EMIT. No read is issued while in EMIT (backpressure stalls the pass).
- WINDOWS_SIZE == ROW_LIMIT: exactly one position.
- rst_n low at any time: immediate return to IDLE, with all counters and the accumulator cleared; the interrupted pass is abandoned with no partial output.

## Timing
- Reset values: tap_rd=0, pix_addr=0, ker_addr=0, out_valid=0, out_data=0, out_row=0, out_col=0, busy=0, done=0.
- All outputs are registered.
- Taking the start-sampling edge as edge 0: taps are registered on edges 0..W²-1, DRAIN ends on edge W²+1, and out_valid is high from edge W²+1.
- Per position: W²+2 cycles with out_ready=1.
- Full pass, out_ready tied 1: (ROW_LIMIT-WINDOWS_SIZE+1)² × (W²+2) edges; done high in the following cycle. Default parameters: 64 × 11 = 704.
- A new start is accepted from the first IDLE cycle, i.e. the same cycle done is high.

## Structure
- Package conv_pkg: state enum (IDLE, ISSUE, DRAIN, EMIT), and width functions for address, position and ACC_W.
- Sub-module conv_index_counter: the nested i/j/m/n counters with last-tap and last-position flags, plus the address computation.
- The FSM, MAC and output register stay in the top module.

## Test plan
- All pixels=1, all kernel=1, default parameters, out_ready=1 → 64 results, each out_data=9, row/col in raster order (0,0)…(7,7), done at edge 704.
- pixel(r,c)=r, kernel center=1 and other taps=0 → out_data(i,j)=i+1 for all j.
- All samples=31 → every out_data=8649, with no truncation at ACC_W=14.
- out_ready low for 5 cycles on the first result → out_valid and out_data stay stable, tap_rd=0, and the pass completes 5 cycles late.
- start pulsed during ISSUE → ignored, and the result sequence is unchanged.
- rst_n low mid-ISSUE on position (3,4) → all outputs return to their reset values at once; a new start then yields a full 64-result pass beginning at (0,0).
